// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite register bridge: response codes,
// FSM state encoding and the default user-response timeout.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_WAIT,
    ST_WR_REG,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP
  } state_e;

  // Map the user's invalid-address flag onto an AXI response code.
  function automatic logic [1:0] resp_of(input logic invalid);
    return invalid ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_reg_bridge_if.sv
// AXI4-Lite slave-side channel bundle used by axi_lite_reg_bridge.
// master: interconnect side; slave: the bridge.
interface axi_lite_reg_bridge_if #(
  parameter int unsigned ADDR_WIDTH = 16
);

  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;

  logic                  wvalid;
  logic                  wready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;

  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;

  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;

  logic                  rvalid;
  logic                  rready;
  logic [1:0]            rresp;
  logic [31:0]           rdata;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata
  );

endinterface

// File: rtl/axi_lite_reg_bridge.sv
// AXI4-Lite to single-outstanding strobe-based register interface.
// One transaction in flight; writes win over a simultaneous read.
// Optional build macro AXI_LITE_TIMEOUT_EN: forces SLVERR when the user
// fails to ack/rdy within TIMEOUT_CYCLES; without it the bridge waits forever.
module axi_lite_reg_bridge
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_lite_reg_bridge_if.slave  axi,
  output logic [ADDR_WIDTH-1:0] o_reg_address,
  input  logic                  i_reg_invalid_addr,
  output logic                  o_reg_in_rdy,
  input  logic                  i_reg_in_ack,
  output logic [31:0]           o_reg_in_data,
  output logic [3:0]            o_reg_in_strb,
  output logic                  o_reg_out_req,
  input  logic                  i_reg_out_rdy,
  input  logic [31:0]           i_reg_out_data
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("axi_lite_reg_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  state_e                state_q, state_d;
  logic                  aw_got_q, w_got_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  in_rdy_q, out_req_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [31:0]           rdata_q;

  logic awready, wready, arready, bvalid, rvalid;
  logic aw_hs, w_hs, ar_hs;
  logic aw_all, w_all;
  logic timeout;

  assign aw_hs  = axi.awvalid & awready;
  assign w_hs   = axi.wvalid & wready;
  assign ar_hs  = axi.arvalid & arready;
  assign aw_all = aw_got_q | aw_hs;
  assign w_all  = w_got_q | w_hs;

`ifdef AXI_LITE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] to_cnt_q;
  logic            waiting;

  assign waiting = (state_q == ST_WR_REG) || (state_q == ST_RD_REQ);
  assign timeout = waiting && (to_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Count cycles spent waiting on the user; cleared in every other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if (waiting) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end else begin
      to_cnt_q <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (aw_hs || w_hs) begin
          state_d = (aw_hs && w_hs) ? ST_WR_REG : ST_WR_WAIT;
        end else if (ar_hs) begin
          state_d = ST_RD_REQ;
        end
      end
      ST_WR_WAIT: if (aw_all && w_all)               state_d = ST_WR_REG;
      ST_WR_REG:  if (i_reg_in_ack || timeout)       state_d = ST_WR_RESP;
      ST_WR_RESP: if (axi.bready)                    state_d = ST_IDLE;
      ST_RD_REQ:  if (i_reg_out_rdy || timeout)      state_d = ST_RD_RESP;
      ST_RD_RESP: if (axi.rready)                    state_d = ST_IDLE;
      default:                                       state_d = ST_IDLE;
    endcase
  end

  // Channel ready/valid outputs decoded from state; all held low in reset.
  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    arready = 1'b0;
    bvalid  = 1'b0;
    rvalid  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_IDLE: begin
          awready = 1'b1;
          wready  = 1'b1;
          arready = !axi.awvalid && !axi.wvalid;
        end
        ST_WR_WAIT: begin
          awready = !aw_got_q;
          wready  = !w_got_q;
        end
        ST_WR_RESP: bvalid = 1'b1;
        ST_RD_RESP: rvalid = 1'b1;
        default: ;
      endcase
    end
  end

  // Capture address/data, generate entry strobes and latch responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      in_rdy_q  <= 1'b0;
      out_req_q <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      if (aw_hs) begin
        addr_q <= axi.awaddr;
      end else if (ar_hs) begin
        addr_q <= axi.araddr;
      end
      if (w_hs) begin
        wdata_q <= axi.wdata;
        wstrb_q <= axi.wstrb;
      end
      // Channel-captured flags only matter while assembling a write.
      aw_got_q  <= ((state_q == ST_IDLE) || (state_q == ST_WR_WAIT)) && aw_all;
      w_got_q   <= ((state_q == ST_IDLE) || (state_q == ST_WR_WAIT)) && w_all;
      in_rdy_q  <= (state_d == ST_WR_REG) && (state_q != ST_WR_REG);
      out_req_q <= (state_d == ST_RD_REQ) && (state_q != ST_RD_REQ);
      // An ack coinciding with the timeout wins; a bare timeout is SLVERR.
      if ((state_q == ST_WR_REG) && (state_d == ST_WR_RESP)) begin
        bresp_q <= i_reg_in_ack ? resp_of(i_reg_invalid_addr) : RESP_SLVERR;
      end
      if ((state_q == ST_RD_REQ) && (state_d == ST_RD_RESP)) begin
        rresp_q <= i_reg_out_rdy ? resp_of(i_reg_invalid_addr) : RESP_SLVERR;
        rdata_q <= i_reg_out_rdy ? i_reg_out_data : '0;
      end
    end
  end

  assign axi.awready = awready;
  assign axi.wready  = wready;
  assign axi.arready = arready;
  assign axi.bvalid  = bvalid;
  assign axi.bresp   = bresp_q;
  assign axi.rvalid  = rvalid;
  assign axi.rresp   = rresp_q;
  assign axi.rdata   = rdata_q;

  assign o_reg_address = addr_q;
  assign o_reg_in_rdy  = in_rdy_q;
  assign o_reg_in_data = wdata_q;
  assign o_reg_in_strb = wstrb_q;
  assign o_reg_out_req = out_req_q;

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Self-checking bench for axi_lite_reg_bridge. The bench plays both the AXI
// master and the user register bank (a 16-word array, addr[4] marks invalid).
// Timeout scenarios are built only when AXI_LITE_TIMEOUT_EN is defined.
module tb_axi_lite_reg_bridge;
  import axi_lite_pkg::*;

  localparam int unsigned AW = 16;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_lite_reg_bridge_if #(.ADDR_WIDTH(AW)) axi ();

  logic [AW-1:0] reg_address;
  logic          invalid, in_rdy, in_ack, out_req, out_rdy;
  logic [31:0]   in_data, out_data;
  logic [3:0]    in_strb;

  axi_lite_reg_bridge #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk               (clk),
    .rst               (rst),
    .axi               (axi.slave),
    .o_reg_address     (reg_address),
    .i_reg_invalid_addr(invalid),
    .o_reg_in_rdy      (in_rdy),
    .i_reg_in_ack      (in_ack),
    .o_reg_in_data     (in_data),
    .o_reg_in_strb     (in_strb),
    .o_reg_out_req     (out_req),
    .i_reg_out_rdy     (out_rdy),
    .i_reg_out_data    (out_data)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] bank [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_invalid(input logic [AW-1:0] a);
    return a[4];
  endfunction

  // Expected latency from user strobe to response valid, and whether the
  // bridge gives up first.
  function automatic int resp_lat(input int dly, output bit tmo);
    tmo = 1'b0;
`ifdef AXI_LITE_TIMEOUT_EN
    if (dly + 1 > int'(TO)) begin
      tmo = 1'b1;
      return int'(TO);
    end
`endif
    return dly + 1;
  endfunction

  task automatic idle_inputs();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    axi.bready  = 1'b0; axi.rready = 1'b0;
    in_ack = 1'b0; out_rdy = 1'b0; invalid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int ack_dly, input int b_dly,
                          input bit hold_ar, input string tag);
    bit inv, tmo, aw_done, w_done, done;
    int cyc, hs_cyc, rdy_cyc, bv_cyc, pulses, lat;
    logic [1:0] exp_resp;
    inv = is_invalid(a);
    lat = resp_lat(ack_dly, tmo);
    exp_resp = (inv || tmo) ? RESP_SLVERR : RESP_OKAY;
    aw_done = 0; w_done = 0; done = 0;
    cyc = 0; hs_cyc = -1; rdy_cyc = -1; bv_cyc = -1; pulses = 0;
    while (!done && cyc < 400) begin
      axi.awvalid = !aw_done && cyc >= aw_dly; axi.awaddr = a;
      axi.wvalid  = !w_done && cyc >= w_dly;   axi.wdata = d; axi.wstrb = s;
      axi.arvalid = hold_ar;
      in_ack      = (rdy_cyc >= 0) && (cyc == rdy_cyc + ack_dly);
      invalid     = in_ack ? inv : 1'($urandom_range(0, 1));
      out_rdy     = 1'($urandom_range(0, 1));
      out_data    = $urandom;
      axi.bready  = (bv_cyc >= 0) && (cyc >= bv_cyc + b_dly);
      @(negedge clk);
      if (hold_ar) chk({tag, ":arready_blocked"}, axi.arready, 0);
      if (aw_done) chk({tag, ":awready_low"}, axi.awready, 0);
      if (w_done)  chk({tag, ":wready_low"}, axi.wready, 0);
      if (axi.awvalid && axi.awready) aw_done = 1;
      if (axi.wvalid && axi.wready)   w_done = 1;
      if (aw_done && w_done && hs_cyc < 0) hs_cyc = cyc;
      if (in_rdy) begin
        pulses++;
        if (rdy_cyc < 0) rdy_cyc = cyc;
        chk({tag, ":reg_address"}, reg_address, a);
        chk({tag, ":reg_in_data"}, in_data, d);
        chk({tag, ":reg_in_strb"}, in_strb, s);
      end
      if (axi.bvalid) begin
        if (bv_cyc < 0) bv_cyc = cyc;
        chk({tag, ":bresp"}, axi.bresp, exp_resp);
        if (axi.bready) done = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    idle_inputs();
    chk({tag, ":b_accepted"}, done, 1);
    chk({tag, ":rdy_pulses"}, pulses, 1);
    chk({tag, ":rdy_after_hs"}, rdy_cyc, hs_cyc + 1);
    chk({tag, ":bvalid_latency"}, bv_cyc - hs_cyc, lat + 1);
    if (!inv && !tmo)
      for (int b = 0; b < 4; b++)
        if (s[b]) bank[a[5:2]][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int ar_dly, input int rdy_dly,
                         input int r_dly, input string tag, output int hs_o);
    bit inv, tmo, ar_done, done;
    int cyc, hs_cyc, req_cyc, rv_cyc, pulses, lat;
    logic [31:0] user_val, exp_data;
    logic [1:0]  exp_resp;
    inv = is_invalid(a);
    lat = resp_lat(rdy_dly, tmo);
    user_val = inv ? 32'h0 : bank[a[5:2]];
    exp_data = tmo ? 32'h0 : user_val;
    exp_resp = (inv || tmo) ? RESP_SLVERR : RESP_OKAY;
    ar_done = 0; done = 0;
    cyc = 0; hs_cyc = -1; req_cyc = -1; rv_cyc = -1; pulses = 0;
    while (!done && cyc < 400) begin
      axi.arvalid = !ar_done && cyc >= ar_dly; axi.araddr = a;
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      out_rdy     = (req_cyc >= 0) && (cyc == req_cyc + rdy_dly);
      out_data    = out_rdy ? user_val : $urandom;
      invalid     = out_rdy ? inv : 1'($urandom_range(0, 1));
      in_ack      = 1'($urandom_range(0, 1));
      axi.rready  = (rv_cyc >= 0) && (cyc >= rv_cyc + r_dly);
      @(negedge clk);
      if (axi.arvalid && axi.arready) begin
        ar_done = 1;
        hs_cyc  = cyc;
      end
      if (out_req) begin
        pulses++;
        if (req_cyc < 0) req_cyc = cyc;
        chk({tag, ":reg_address"}, reg_address, a);
      end
      if (axi.rvalid) begin
        if (rv_cyc < 0) rv_cyc = cyc;
        chk({tag, ":rdata"}, axi.rdata, exp_data);
        chk({tag, ":rresp"}, axi.rresp, exp_resp);
        if (axi.rready) done = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    idle_inputs();
    hs_o = hs_cyc;
    chk({tag, ":r_accepted"}, done, 1);
    chk({tag, ":req_pulses"}, pulses, 1);
    chk({tag, ":req_after_hs"}, req_cyc, hs_cyc + 1);
    chk({tag, ":rvalid_latency"}, rv_cyc - hs_cyc, lat + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    int guard;
    logic [AW-1:0] ra;
    rst = 1'b1;
    idle_inputs();
    axi.awaddr = '0; axi.araddr = '0; axi.wdata = '0; axi.wstrb = '0; out_data = '0;
    for (int i = 0; i < 16; i++) bank[i] = $urandom;
    bank[0] = 32'h1234_5678;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset:awready", axi.awready, 0);
    chk("reset:wready",  axi.wready, 0);
    chk("reset:arready", axi.arready, 0);
    chk("reset:bvalid",  axi.bvalid, 0);
    chk("reset:rvalid",  axi.rvalid, 0);
    chk("reset:bresp",   axi.bresp, 0);
    chk("reset:rresp",   axi.rresp, 0);
    chk("reset:rdata",   axi.rdata, 0);
    chk("reset:reg_in_rdy", in_rdy, 0);
    chk("reset:reg_out_req", out_req, 0);
    chk("reset:reg_address", reg_address, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed: same-cycle AW+W, prompt ack.
    do_write(16'h0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 1, 1, 0, "t1_write");
    // Directed: read with rready held low for 5 cycles.
    do_read(16'h0000, 0, 1, 5, "t2_read", hs);
    // Directed: invalid address on write and read.
    do_write(16'h0010, 32'hCAFE_F00D, 4'hF, 0, 0, 1, 1, 0, "t3_write_inv");
    do_read(16'h0010, 0, 2, 1, "t3_read_inv", hs);
    // Directed: W arrives three cycles ahead of AW.
    do_write(16'h0008, 32'hA5A5_0F0F, 4'b0101, 3, 0, 2, 1, 0, "t4_w_first");
    // Directed: AW+W+AR together; write completes, then read goes at once.
    axi.araddr = 16'h0004;
    do_write(16'h000C, 32'h0BAD_F00D, 4'hF, 0, 0, 1, 2, 1, "t5_write");
    axi.arvalid = 1'b1;
    do_read(16'h0004, 0, 1, 1, "t5_read", hs);
    chk("t5:read_immediate", hs, 0);

    // Reset while the bridge waits for the user ack.
    axi.awvalid = 1'b1; axi.awaddr = 16'h0020; axi.wvalid = 1'b1;
    axi.wdata = 32'h1111_2222; axi.wstrb = 4'hF;
    guard = 0;
    @(negedge clk);
    @(posedge clk); #1;
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    @(negedge clk);
    chk("rst_mid:rdy_seen", in_rdy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid:awready", axi.awready, 0);
    chk("rst_mid:bvalid", axi.bvalid, 0);
    chk("rst_mid:reg_in_rdy", in_rdy, 0);
    chk("rst_mid:reg_address", reg_address, 0);
    chk("rst_mid:reg_in_data", in_data, 0);
    chk("rst_mid:reg_in_strb", in_strb, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_ack = 1'b1;
    @(posedge clk); #1;
    in_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid:no_bvalid", axi.bvalid, 0);
      chk("rst_mid:idle_arready", axi.arready, 1);
      @(posedge clk); #1;
    end

    // Randomized mix checked against the register-bank model.
    for (int n = 0; n < 30; n++) begin
      ra = AW'({$urandom_range(0, 15), 2'b00});
      if ($urandom_range(0, 1) == 1)
        do_write(ra, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                 int'($urandom_range(1, 3)), 0, "rand_write");
      else
        do_read(ra, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                int'($urandom_range(1, 3)), "rand_read", hs);
    end

`ifdef AXI_LITE_TIMEOUT_EN
    do_write(16'h0004, 32'h7777_8888, 4'hF, 0, 0, 1000, 1, 0, "to_write");
    do_read(16'h0004, 0, 1000, 1, "to_read", hs);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_bridge.md
Name: axi_lite_reg_bridge

Overview:
Converts AXI4-Lite slave channels into a single-outstanding, strobe-based register interface for user register banks.
- Sits directly between the AXI interconnect and the user register-map logic, inside each peripheral's top.
- Serialises reads and writes: one transaction in flight at a time.
- Returns OKAY or SLVERR from the user's invalid-address flag.

Parameters:
- ADDR_WIDTH, 16, width of AXI byte address and o_reg_address.
- TIMEOUT_CYCLES, 256, cycles to wait for user ack/rdy before forcing SLVERR; used only with AXI_LITE_TIMEOUT_EN.

Ports:
- clk  in  1  clock for all logic.
- rst  in  1  reset; synchronous, active-high.
- i_awvalid  in  1  write address valid.
- i_awaddr  in  ADDR_WIDTH  write address.
- o_awready  out  1  write address ready.
- i_wvalid  in  1  write data valid.
- o_wready  out  1  write data ready.
- i_wdata  in  32  write data.
- i_wstrb  in  4  write byte strobes.
- o_bvalid  out  1  write response valid.
- i_bready  in  1  write response ready.
- o_bresp  out  2  write response code.
- i_arvalid  in  1  read address valid.
- o_arready  out  1  read address ready.
- i_araddr  in  ADDR_WIDTH  read address.
- o_rvalid  out  1  read data valid.
- i_rready  in  1  read data ready.
- o_rresp  out  2  read response code.
- o_rdata  out  32  read data.
- o_reg_address  out  ADDR_WIDTH  captured address of current transaction.
- i_reg_invalid_addr  in  1  user flags bad address; sampled with ack/rdy.
- o_reg_in_rdy  out  1  one-cycle strobe: write data valid for user.
- i_reg_in_ack  in  1  user has consumed write.
- o_reg_in_data  out  32  captured write data.
- o_reg_in_strb  out  4  captured write strobes.
- o_reg_out_req  out  1  one-cycle strobe: user must supply read data.
- i_reg_out_rdy  in  1  user read data valid.
- i_reg_out_data  in  32  user read data.

Behaviour:
Reset:
- All outputs 0; o_bresp and o_rresp = 2'b00.
- FSM = IDLE; captured address, data, strobe and flags cleared.
- Reset mid-transaction aborts it with no response issued.

FSM states:
- IDLE
  - If i_awvalid or i_wvalid is high: accept whichever is valid, go WR_WAIT. Writes have priority over a simultaneous i_arvalid.
  - Else if i_arvalid: capture i_araddr, go RD_REQ.
- WR_WAIT
  - o_awready high until AW is captured; o_wready high until W is captured.
  - Both captured → WR_REG. Same-cycle AW+W acceptance in IDLE goes straight to WR_REG.
- WR_REG
  - o_reg_in_rdy pulses exactly one cycle on entry, then waits for i_reg_in_ack.
  - On ack: latch o_bresp = i_reg_invalid_addr ? 2'b10 : 2'b00, go WR_RESP.
- WR_RESP
  - o_bvalid high until i_bready, then IDLE.
- RD_REQ
  - o_reg_out_req pulses one cycle on entry, then waits for i_reg_out_rdy.
  - On rdy: latch o_rdata = i_reg_out_data and o_rresp (SLVERR if invalid), go RD_RESP.
- RD_RESP
  - o_rvalid high until i_rready, then IDLE.

Handshakes and timing:
- o_arready = (state==IDLE) && !i_awvalid && !i_wvalid.
- o_awready/o_wready are high in IDLE and WR_WAIT for the not-yet-captured channel.
- o_reg_address holds the captured address from capture until return to IDLE.
- Ack/rdy arriving in any state other than the one waiting for it is ignored.
- Minimum write latency, AW+W to bvalid: 3 cycles, with the user acking 1 cycle after rdy.
- Read latency is the same.
- bvalid/rvalid, bresp/rresp and rdata are held stable until accepted.

Optional Feature:
Macro AXI_LITE_TIMEOUT_EN.
- Defined: a counter runs in WR_REG and RD_REQ. On reaching TIMEOUT_CYCLES without ack/rdy, the bridge returns SLVERR (rdata=0) and proceeds to the response state. A late ack/rdy is then ignored.
- Undefined: the bridge waits indefinitely, and no counter is synthesised.

Decomposition:
Shared package axi_lite_pkg holds:
- Response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
- State encodings.
- Default TIMEOUT_CYCLES.

No sub-module is needed; the timeout counter stays inline.

Test Plan:
1. Write: AW 0x0004 and W 0xDEADBEEF with strb 4'hF in the same cycle; user acks 1 cycle after rdy with invalid=0 → single rdy pulse with addr 0x0004 and data 0xDEADBEEF; bvalid with bresp 00 three cycles after the handshake.
2. Read 0x0000, user returns 0x12345678 → single req pulse; rvalid with rdata 0x12345678 and rresp 00; rvalid held while rready is low for 5 cycles.
3. Write to 0x0010 with the user raising invalid alongside ack → bresp 2'b10. Read of 0x0010 → rresp 2'b10, rdata 0.
4. W arrives 3 cycles before AW → wready drops after W is captured; a single rdy pulse follows only after AW is captured; captured data is correct.
5. Simultaneous AW+W+AR → write completes first (bvalid), then arready and the read proceed.
6. With AXI_LITE_TIMEOUT_EN and TIMEOUT_CYCLES=8, user never acks → bresp 2'b10 after 8 cycles. Separately, assert rst during WR_REG → all outputs 0 next cycle and FSM in IDLE.
